serial_addsub_unit: RTL and testbench
=====================================

# serial_addsub_unit

Parametrised bit-serial add/subtract unit with an integrated controller. It replaces the fixed 8-bit serial-adder arrangement of a separate controller, three shift registers and a carry DFF with a single block. The block has width set by parameter, an add/subtract mode, signed-overflow and carry flags, an abort input, and a registered result that holds until the next completed operation. It sits between the operand source and the result consumer in the serial arithmetic path.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  level request; sampled in IDLE.
- ABORT  input  1  cancels an operation in progress; ignored outside SHIFT.
- MODE  input  1  0 = A+B, 1 = A−B (two's complement).
- A  input  WIDTH  operand A; sampled on the start edge.
- B  input  WIDTH  operand B; sampled on the start edge.
- SUM  output  WIDTH  last completed result (registered).
- COUT  output  1  carry out of MSB; for subtract, 1 = no borrow.
- OVF  output  1  signed overflow of last completed result.
- BUSY  output  1  high while in SHIFT.
- DONE  output  1  high in DONE state.

## Operation
- States: IDLE, SHIFT, DONE.
- **Reset (RST=1):** the block goes to IDLE. SUM=0, COUT=0, OVF=0, BUSY=0, DONE=0, and all internal shift registers, carry and count are cleared. This applies immediately, including mid-operation.
- **IDLE, START=1 at a rising edge:**
  - Capture opA←A, opB←(MODE ? ~B : B), carry←MODE, count←0, partial←0.
  - Go to SHIFT.
- **IDLE, START=0:** stay in IDLE.
- **SHIFT, each edge:**
  - s = opA[0]^opB[0]^carry.
  - partial ← {s, partial[WIDTH-1:1]}.
  - opA and opB shift right, LSB first.
  - carry ← maj(opA[0], opB[0], carry).
  - count ← count+1.
  - Record the carry-in of the MSB when count==WIDTH-1.
- **SHIFT, edge with count==WIDTH-1:** the last bit is processed, and in the same edge:
  - SUM←{s, partial[WIDTH-1:1]}.
  - COUT←new carry.
  - OVF←(MSB carry-in ^ new carry).
  - Go to DONE.
- **SHIFT, ABORT=1 at an edge:** ABORT has priority over the bit step and the completion step. The block goes to IDLE, and SUM/COUT/OVF keep their previous values.
- **DONE:** stay while START=1. When START=0 at an edge, go to IDLE. The block does not restart while START is held high.
- SUM, COUT and OVF change only on a completion edge or on reset.
- The internal count width is $clog2(WIDTH+1) bits. Arithmetic is modulo 2^WIDTH.

## Timing
- Edge k: the block is in IDLE with START=1, and A/B/MODE are captured. From cycle k+1, BUSY=1.
- Edges k+1 .. k+WIDTH: WIDTH bit steps. Edge k+WIDTH is the completion edge.
- After edge k+WIDTH: BUSY=0 and DONE=1, with SUM/COUT/OVF valid in the same cycle.
- Latency from capture edge to DONE is exactly WIDTH cycles.
- **Minimum back-to-back cycle:** the operation takes WIDTH cycles, plus at least 1 DONE cycle, plus 1 IDLE cycle, giving WIDTH+2 edges per operation.
- A and B may change freely after edge k.
- ABORT and START during SHIFT have no effect other than as stated above.
- BUSY and DONE are decoded from the state register only, with no combinational path from the inputs.

## Test plan
- **Add, WIDTH=8:** A=0x5A, B=0x3C, MODE=0, pulse START.
  - DONE rises exactly 8 cycles after capture.
  - SUM=0x96, COUT=0, OVF=1.
- **Subtract, WIDTH=8, two operations back to back:**
  - A=0x10, B=0x20, MODE=1 → SUM=0xF0, COUT=0, OVF=0.
  - Then A=0x80, B=0x01 → SUM=0x7F, COUT=1, OVF=1.
- **Wrap, WIDTH=8:** A=0xFF, B=0x01, MODE=0 → SUM=0x00, COUT=1, OVF=0.
  - Holding START high keeps DONE=1 with no new operation.
  - Dropping START gives IDLE on the next edge.
- **Abort:**
  - Complete 0x5A+0x3C, then start 0x01+0x01.
  - Assert ABORT at bit step 3 → IDLE next edge, BUSY=0, DONE never rises.
  - SUM stays 0x96.
- **Reset mid-operation:**
  - Assert RST asynchronously at bit step 5 → all outputs 0 immediately.
  - After release with START=1, a fresh operation completes correctly.
- **WIDTH=16 instance:** A=0xFFFF, B=0xFFFF, MODE=0.
  - DONE rises after 16 cycles.
  - SUM=0xFFFE, COUT=1, OVF=0.

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract unit: operands are captured on START, processed LSB first
// one bit per clock, and the registered result/flags hold until the next completion.
module serial_addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Request/completion handshake: START is a level request sampled only in IDLE;
  // DONE stays high until START is seen low, so a held START never retriggers.
  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-2:0] partial;
  logic             carry;
  logic [CW-1:0]    count;

  logic             s_bit;
  logic             c_next;
  logic             last_step;
  logic [WIDTH-1:0] shifted;

  assign s_bit     = op_a[0] ^ op_b[0] ^ carry;
  assign c_next    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign shifted   = {s_bit, partial};
  assign last_step = (count == CW'(WIDTH - 1));

  assign BUSY = (state == S_SHIFT);
  assign DONE = (state == S_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      partial <= '0;
      carry   <= 1'b0;
      count   <= '0;
      SUM     <= '0;
      COUT    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            op_a    <= A;
            op_b    <= MODE ? ~B : B;
            carry   <= MODE;
            count   <= '0;
            partial <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ABORT) begin
            state <= S_IDLE;
          end else begin
            partial <= shifted[WIDTH-1:1];
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            carry   <= c_next;
            count   <= count + CW'(1);
            // On the MSB step the current carry is the MSB carry-in.
            if (last_step) begin
              SUM   <= shifted;
              COUT  <= c_next;
              OVF   <= carry ^ c_next;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!START) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: an 8-bit and a 16-bit instance on one clock.
module tb_serial_addsub_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start8 = 1'b0, abort8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  sum8;
  logic        cout8, ovf8, busy8, done8;

  logic        start16 = 1'b0, abort16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] sum16;
  logic        cout16, ovf16, busy16, done16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .ABORT(abort8), .MODE(mode8),
    .A(a8), .B(b8), .SUM(sum8), .COUT(cout8), .OVF(ovf8), .BUSY(busy8), .DONE(done8)
  );

  serial_addsub_unit #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .START(start16), .ABORT(abort16), .MODE(mode16),
    .A(a16), .B(b16), .SUM(sum16), .COUT(cout16), .OVF(ovf16), .BUSY(busy16), .DONE(done16)
  );

  // Driver: present operands, capture on one edge, drop START, return #1 after the edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic m);
    @(negedge clk);
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts edges after capture until DONE, bounded.
  task automatic wait_done8(output int cycles);
    cycles = 0;
    while (!done8 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      failures++;
      $display("FAIL reset8: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               sum8, cout8, ovf8, busy8, done8);
    end
    checks++;
    if ({sum16, cout16, ovf16, busy16, done16} !== 20'h00000) begin
      failures++;
      $display("FAIL reset16: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               sum16, cout16, ovf16, busy16, done16);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    start_op8(8'h5A, 8'h3C, 1'b0);
    checks++;
    if (busy8 !== 1'b1) begin
      failures++; $display("FAIL add_busy: got %b want 1", busy8);
    end
    wait_done8(cyc);
    checks++;
    if (cyc != 8) begin
      failures++; $display("FAIL add_latency: got %0d want 8", cyc);
    end
    checks++;
    if ({sum8, cout8, ovf8, busy8} !== {8'h96, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_result: got sum=%h cout=%b ovf=%b busy=%b want 96 0 1 0",
               sum8, cout8, ovf8, busy8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op8(8'h10, 8'h20, 1'b1);
    wait_done8(cyc);
    checks++;
    if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0} || cyc != 8) begin
      failures++;
      $display("FAIL sub1: got sum=%h cout=%b ovf=%b lat=%0d want F0 0 0 8",
               sum8, cout8, ovf8, cyc);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy8, done8);
    end
    start_op8(8'h80, 8'h01, 1'b1);
    checks++;
    if (busy8 !== 1'b1) begin
      failures++; $display("FAIL b2b_restart: got busy=%b want 1", busy8);
    end
    wait_done8(cyc);
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1} || cyc != 8) begin
      failures++;
      $display("FAIL sub2: got sum=%h cout=%b ovf=%b lat=%0d want 7F 1 1 8",
               sum8, cout8, ovf8, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_hold();
    int cyc;
    logic held_ok;
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc);
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL wrap: got sum=%h cout=%b ovf=%b want 00 1 0", sum8, cout8, ovf8);
    end
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    held_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== 8'h00) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL hold_done: got done=%b busy=%b sum=%h want 1 0 00", done8, busy8, sum8);
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++; $display("FAIL drop_start: got busy=%b done=%b want 0 0", busy8, done8);
    end
  endtask

  task automatic test_abort();
    int cyc;
    logic saw_done;
    start_op8(8'h5A, 8'h3C, 1'b0);
    wait_done8(cyc);
    @(posedge clk); #1;
    start_op8(8'h01, 8'h01, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort8 = 1'b1;
    @(posedge clk); #1;
    abort8 = 1'b0;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy8, done8);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++; $display("FAIL abort_quiet: got activity=1 want 0");
    end
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_keep: got sum=%h cout=%b ovf=%b want 96 0 1", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    start_op8(8'h01, 8'h02, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid: got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               sum8, cout8, ovf8, busy8, done8);
    end
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; mode8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(cyc);
    checks++;
    if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0} || cyc != 8) begin
      failures++;
      $display("FAIL after_reset: got sum=%h cout=%b ovf=%b lat=%0d want F0 0 0 8",
               sum8, cout8, ovf8, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width16();
    int cyc;
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; mode16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 16) begin
      failures++; $display("FAIL w16_latency: got %0d want 16", cyc);
    end
    checks++;
    if ({sum16, cout16, ovf16} !== {16'hFFFE, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL w16_result: got sum=%h cout=%b ovf=%b want FFFE 1 0", sum16, cout16, ovf16);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_wrap_hold();
    test_abort();
    test_reset_mid_op();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
